// File: rtl/cipher_pkg.sv
// Shared types and defaults for the pixel XOR stream-cipher engine.
// Provides the FSM state enum, mode encodings and default geometry.
package cipher_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    localparam int DEF_NUM_CH = 3;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16384;

endpackage

// File: rtl/pixel_xor_cipher_if.sv
// Bus bundle for pixel_xor_cipher: frame control, keystream handshake,
// frame-buffer read/write ports and status. slave = engine, master = user.
interface pixel_xor_cipher_if
    import cipher_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) ();
    localparam int W      = NUM_CH * DATA_W;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              start;
    logic              mode;
    logic              chain_en;
    logic [W-1:0]      iv;
    logic [ADDR_W:0]   length;
    logic              ks_valid;
    logic [W-1:0]      ks_data;
    logic              ks_ready;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [W-1:0]      rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [W-1:0]      wr_data;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, mode, chain_en, iv, length,
        output ks_valid, ks_data, rd_data,
        input  ks_ready, rd_en, rd_addr,
        input  wr_en, wr_addr, wr_data,
        input  busy, done, err
    );

    modport slave (
        input  start, mode, chain_en, iv, length,
        input  ks_valid, ks_data, rd_data,
        output ks_ready, rd_en, rd_addr,
        output wr_en, wr_addr, wr_data,
        output busy, done, err
    );

endinterface

// File: rtl/xor_chain_lane.sv
// One channel of the compute stage: out = d ^ k (^ chain when enabled).
// Ports: load_i reloads chain from iv_i; step_i advances chain on a write.
module xor_chain_lane
    import cipher_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              chain_en_i,
    input  logic              mode_i,
    input  logic [DATA_W-1:0] iv_i,
    input  logic [DATA_W-1:0] d_i,
    input  logic [DATA_W-1:0] k_i,
    output logic [DATA_W-1:0] out_o
);
    logic [DATA_W-1:0] chain_q;
    logic [DATA_W-1:0] chain_d;
    logic [DATA_W-1:0] out;

    // Decrypt chains on the incoming ciphertext, encrypt on its own output,
    // so both directions carry the same ciphertext history.
    always_comb begin
        out     = d_i ^ k_i;
        chain_d = chain_q;
        if (chain_en_i) begin
            out = out ^ chain_q;
        end
        if (load_i) begin
            chain_d = iv_i;
        end else if (step_i && chain_en_i) begin
            chain_d = (mode_i == MODE_DEC) ? d_i : out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign out_o = out;

endmodule

// File: rtl/pixel_xor_cipher.sv
// Frame-walking XOR stream cipher: one keystream word per pixel, 1-cycle
// read-to-write pipeline. Ports: clk, rst (async, high), cif (slave bus).
module pixel_xor_cipher
    import cipher_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    pixel_xor_cipher_if.slave   cif
);
    localparam int W      = NUM_CH * DATA_W;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    state_t            state_q, state_d;
    logic              mode_q, mode_d;
    logic              cen_q, cen_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   issue_q, issue_d;
    logic [W-1:0]      ks_q, ks_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [W-1:0]      lane_out;

    logic idle_like;
    logic len_ok;
    logic accept;
    logic issue;

    assign idle_like = (state_q == IDLE) || (state_q == DONE);
    assign len_ok    = (cif.length != '0) && (cif.length <= DEPTH_L);
    assign accept    = idle_like && cif.start && len_ok;
    assign issue     = (state_q == RUN) && cif.ks_valid;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        cen_d     = cen_q;
        len_d     = len_q;
        issue_d   = issue_q;
        ks_d      = ks_q;
        wr_en_d   = issue;
        wr_addr_d = wr_addr_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    mode_d  = cif.mode;
                    cen_d   = cif.chain_en;
                    len_d   = cif.length;
                    issue_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (issue) begin
                    ks_d      = cif.ks_data;
                    issue_d   = issue_q + 1'b1;
                    wr_addr_d = issue_q[ADDR_W-1:0];
                    if (issue_q == len_q - 1'b1) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (wr_en_q) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mode_q    <= MODE_ENC;
            cen_q     <= 1'b0;
            len_q     <= '0;
            issue_q   <= '0;
            ks_q      <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            cen_q     <= cen_d;
            len_q     <= len_d;
            issue_q   <= issue_d;
            ks_q      <= ks_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        xor_chain_lane #(
            .DATA_W (DATA_W)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .load_i     (accept),
            .step_i     (wr_en_q),
            .chain_en_i (cen_q),
            .mode_i     (mode_q),
            .iv_i       (cif.iv[g*DATA_W +: DATA_W]),
            .d_i        (cif.rd_data[g*DATA_W +: DATA_W]),
            .k_i        (ks_q[g*DATA_W +: DATA_W]),
            .out_o      (lane_out[g*DATA_W +: DATA_W])
        );
    end

    assign cif.ks_ready = issue;
    assign cif.rd_en    = issue;
    assign cif.rd_addr  = issue_q[ADDR_W-1:0];
    assign cif.wr_en    = wr_en_q;
    assign cif.wr_addr  = wr_addr_q;
    // Gated so the write bus reads 0 whenever no write is in flight.
    assign cif.wr_data  = wr_en_q ? lane_out : '0;
    assign cif.busy     = (state_q == RUN) || (state_q == FLUSH);
    assign cif.done     = (state_q == DONE);
    assign cif.err      = idle_like && cif.start && !len_ok;

endmodule

// File: tb/tb_pixel_xor_cipher.sv
// Directed testbench for pixel_xor_cipher with a frame-buffer model,
// a keystream source and a write log.
module tb_pixel_xor_cipher;
    import cipher_pkg::*;

    localparam int NUM_CH = 3;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16384;
    localparam int W      = NUM_CH * DATA_W;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LOGN   = 32768;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pixel_xor_cipher_if #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) cif ();

    pixel_xor_cipher #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .cif (cif)
    );

    logic [W-1:0]      mem    [DEPTH];
    logic [W-1:0]      ksarr  [DEPTH];
    logic [W-1:0]      expv   [DEPTH];
    logic [W-1:0]      orig   [256];
    logic [W-1:0]      enc_ch [256];
    logic [ADDR_W-1:0] wlog_addr [LOGN];
    logic [W-1:0]      wlog_data [LOGN];
    int                wlog_cyc  [LOGN];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ks_idx = 0;
    int ks_base = 0;
    int wr_count = 0;
    int gap_viol = 0;
    int gcnt = 0;
    logic gap_en = 1'b0;

    assign cif.ks_data = ksarr[(ks_idx - ks_base) % DEPTH];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cif.ks_ready) ks_idx <= ks_idx + 1;
        if (cif.rd_en) cif.rd_data <= mem[cif.rd_addr];
        if (cif.wr_en) begin
            wlog_addr[wr_count] <= cif.wr_addr;
            wlog_data[wr_count] <= cif.wr_data;
            wlog_cyc[wr_count]  <= cyc;
            wr_count <= wr_count + 1;
        end
    end

    always @(posedge clk) begin
        #1;
        if (gap_en) cif.ks_valid = (gcnt % 3 != 2);
        else        cif.ks_valid = 1'b1;
        gcnt = gcnt + 1;
    end

    always @(negedge clk) begin
        if ((!cif.ks_valid && (cif.rd_en || cif.ks_ready)) ||
            (cif.rd_en != cif.ks_ready))
            gap_viol <= gap_viol + 1;
    end

    function automatic void model(input logic m, input logic ce,
                                  input logic [W-1:0] ivv, input int len);
        logic [W-1:0] c, o;
        c = ivv;
        for (int i = 0; i < len; i++) begin
            o = mem[i] ^ ksarr[i];
            if (ce) begin
                o = o ^ c;
                c = m ? mem[i] : o;
            end
            expv[i] = o;
        end
    endfunction

    int wbase;

    task automatic kick(input logic m, input logic ce,
                        input logic [W-1:0] ivv, input int len);
        @(negedge clk);
        ks_base = ks_idx;
        wbase = wr_count;
        cif.start = 1'b1;
        cif.mode = m;
        cif.chain_en = ce;
        cif.iv = ivv;
        cif.length = len[ADDR_W:0];
        @(posedge clk);
        @(negedge clk);
        cif.start = 1'b0;
    endtask

    task automatic wait_done(input int len, input int n0, output int n);
        n = n0;
        while (!cif.done && n < len * 4 + 50) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        checks++;
        if (!cif.done) begin
            errors++;
            $display("FAIL done_timeout: done=%b after %0d cycles, expected 1", cif.done, n);
        end
    endtask

    task automatic run_frame(input logic m, input logic ce,
                             input logic [W-1:0] ivv, input int len,
                             output int cycles);
        kick(m, ce, ivv, len);
        wait_done(len, 1, cycles);
    endtask

    task automatic cmp_frame(input string nm, input int len);
        int bad;
        checks++;
        if (wr_count - wbase !== len) begin
            errors++;
            $display("FAIL %s_count: got %0d writes, expected %0d", nm, wr_count - wbase, len);
        end
        bad = 0;
        for (int i = 0; i < len; i++) begin
            if (wlog_addr[wbase+i] !== i[ADDR_W-1:0] || wlog_data[wbase+i] !== expv[i]) begin
                if (bad == 0)
                    $display("FAIL %s_data: pixel %0d got addr %0d data %h, expected addr %0d data %h",
                             nm, i, wlog_addr[wbase+i], wlog_data[wbase+i], i, expv[i]);
                bad++;
            end
        end
        checks++;
        if (bad != 0) errors++;
    endtask

    task automatic test_reset;
        @(negedge clk);
        #1;
        checks++;
        if ({cif.busy, cif.done, cif.err, cif.wr_en, cif.rd_en, cif.ks_ready} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, expected 000000",
                     {cif.busy, cif.done, cif.err, cif.wr_en, cif.rd_en, cif.ks_ready});
        end
        checks++;
        if (cif.wr_data !== '0 || cif.wr_addr !== '0 || cif.rd_addr !== '0) begin
            errors++;
            $display("FAIL reset_bus: wr_data %h wr_addr %0d rd_addr %0d, expected 0",
                     cif.wr_data, cif.wr_addr, cif.rd_addr);
        end
    endtask

    task automatic test_basic;
        int n;
        for (int i = 0; i < 4; i++) begin
            mem[i] = 24'h102030 + W'(i) * 24'h010101;
            ksarr[i] = 24'h0F0F0F;
        end
        expv[0] = 24'h1F2F3F;
        expv[1] = 24'h1E2E3E;
        expv[2] = 24'h1D2D3D;
        expv[3] = 24'h1C2C3C;
        run_frame(MODE_ENC, 1'b0, 24'h0, 4, n);
        cmp_frame("basic", 4);
        checks++;
        if (n !== 6) begin
            errors++;
            $display("FAIL basic_latency: got %0d cycles, expected 6", n);
        end
        checks++;
        if (cyc - wlog_cyc[wr_count-1] !== 1) begin
            errors++;
            $display("FAIL basic_done_edge: got %0d cycles after last write, expected 1",
                     cyc - wlog_cyc[wr_count-1]);
        end
        checks++;
        if (cif.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy: got %b, expected 0", cif.busy);
        end
    endtask

    task automatic test_chain;
        int n, diff, bad;
        mem[0] = 24'h010203;
        mem[1] = 24'h040506;
        ksarr[0] = 24'h0F0F0F;
        ksarr[1] = 24'h0F0F0F;
        expv[0] = 24'hABA8A9;
        expv[1] = 24'hA0A2A0;
        run_frame(MODE_ENC, 1'b1, 24'hA5A5A5, 2, n);
        cmp_frame("chain_hand", 2);
        for (int i = 0; i < 256; i++) begin
            orig[i] = W'($urandom);
            mem[i] = orig[i];
            ksarr[i] = W'($urandom);
        end
        model(MODE_ENC, 1'b1, 24'hA5A5A5, 256);
        run_frame(MODE_ENC, 1'b1, 24'hA5A5A5, 256, n);
        cmp_frame("chain_enc", 256);
        for (int i = 0; i < 256; i++) enc_ch[i] = wlog_data[wbase+i];
        model(MODE_ENC, 1'b0, 24'hA5A5A5, 256);
        run_frame(MODE_ENC, 1'b0, 24'hA5A5A5, 256, n);
        cmp_frame("plain_enc", 256);
        diff = 0;
        for (int i = 0; i < 256; i++)
            if (enc_ch[i] !== wlog_data[wbase+i]) diff++;
        checks++;
        if (diff == 0) begin
            errors++;
            $display("FAIL chain_differs: got %0d differing pixels, expected > 0", diff);
        end
        for (int i = 0; i < 256; i++) mem[i] = enc_ch[i];
        run_frame(MODE_DEC, 1'b1, 24'hA5A5A5, 256, n);
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (wlog_data[wbase+i] !== orig[i]) bad++;
        checks++;
        if (bad != 0 || wr_count - wbase != 256) begin
            errors++;
            $display("FAIL chain_roundtrip: got %0d bad pixels of %0d writes, expected 0 of 256",
                     bad, wr_count - wbase);
        end
    endtask

    task automatic test_gaps;
        int n, gv0;
        for (int i = 0; i < 16; i++) begin
            mem[i] = W'($urandom);
            ksarr[i] = W'($urandom);
        end
        model(MODE_ENC, 1'b1, 24'h123456, 16);
        gv0 = gap_viol;
        gap_en = 1'b1;
        run_frame(MODE_ENC, 1'b1, 24'h123456, 16, n);
        gap_en = 1'b0;
        cmp_frame("gaps", 16);
        checks++;
        if (gap_viol != gv0) begin
            errors++;
            $display("FAIL gaps_handshake: got %0d violations, expected 0", gap_viol - gv0);
        end
        checks++;
        if (n < 25) begin
            errors++;
            $display("FAIL gaps_cycles: got %0d cycles, expected >= 25", n);
        end
    endtask

    task automatic test_boundary;
        int n, bad, wb;
        int bl [2];
        mem[0] = 24'hABCDEF;
        ksarr[0] = 24'h111111;
        expv[0] = 24'hBADCFE;
        run_frame(MODE_ENC, 1'b0, 24'h0, 1, n);
        cmp_frame("len1", 1);
        checks++;
        if (n !== 3) begin
            errors++;
            $display("FAIL len1_latency: got %0d cycles, expected 3", n);
        end
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = W'(i);
            ksarr[i] = 24'h5A5A5A;
        end
        model(MODE_ENC, 1'b0, 24'h0, DEPTH);
        run_frame(MODE_ENC, 1'b0, 24'h0, DEPTH, n);
        cmp_frame("lenmax", DEPTH);
        checks++;
        if (wlog_addr[wr_count-1] !== ADDR_W'(DEPTH - 1) || wlog_data[wr_count-1] !== 24'h5A65A5) begin
            errors++;
            $display("FAIL lenmax_last: got addr %0d data %h, expected addr %0d data 5a65a5",
                     wlog_addr[wr_count-1], wlog_data[wr_count-1], DEPTH - 1);
        end
        bl[0] = 0;
        bl[1] = DEPTH + 1;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            wb = wr_count;
            cif.start = 1'b1;
            cif.length = bl[b][ADDR_W:0];
            #1;
            checks++;
            if (cif.err !== 1'b1 || cif.busy !== 1'b0) begin
                errors++;
                $display("FAIL badlen_err: len %0d err=%b busy=%b, expected err=1 busy=0",
                         bl[b], cif.err, cif.busy);
            end
            @(negedge clk);
            cif.start = 1'b0;
            #1;
            checks++;
            if (cif.err !== 1'b0 || cif.busy !== 1'b0 || cif.done !== 1'b1) begin
                errors++;
                $display("FAIL badlen_after: len %0d err=%b busy=%b done=%b, expected 0 0 1",
                         bl[b], cif.err, cif.busy, cif.done);
            end
            repeat (4) @(negedge clk);
            checks++;
            if (wr_count != wb) begin
                errors++;
                $display("FAIL badlen_writes: got %0d writes, expected 0", wr_count - wb);
            end
        end
    endtask

    task automatic test_reset_mid;
        int n, wb;
        for (int i = 0; i < 10; i++) begin
            mem[i] = W'($urandom);
            ksarr[i] = W'($urandom);
        end
        kick(MODE_ENC, 1'b1, 24'h3C3C3C, 10);
        n = 0;
        while (!(cif.rd_en && cif.rd_addr == 5) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(cif.rd_en && cif.rd_addr == 5)) begin
            errors++;
            $display("FAIL rstmid_reach: rd_addr %0d rd_en %b, expected pixel 5 issue",
                     cif.rd_addr, cif.rd_en);
        end
        rst = 1'b1;
        #1;
        wb = wr_count;
        checks++;
        if ({cif.busy, cif.done, cif.err, cif.wr_en, cif.rd_en, cif.ks_ready} !== 6'b0 ||
            cif.wr_data !== '0 || cif.wr_addr !== '0 || cif.rd_addr !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: ctrl %b wr_data %h wr_addr %0d rd_addr %0d, expected all 0",
                     {cif.busy, cif.done, cif.err, cif.wr_en, cif.rd_en, cif.ks_ready},
                     cif.wr_data, cif.wr_addr, cif.rd_addr);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (wr_count != wb) begin
            errors++;
            $display("FAIL rstmid_writes: got %0d writes after reset, expected 0", wr_count - wb);
        end
        model(MODE_ENC, 1'b1, 24'hC3C3C3, 3);
        run_frame(MODE_ENC, 1'b1, 24'hC3C3C3, 3, n);
        cmp_frame("rstmid_restart", 3);
    endtask

    task automatic test_start_during_run;
        int n;
        for (int i = 0; i < 8; i++) begin
            mem[i] = W'($urandom);
            ksarr[i] = W'($urandom);
        end
        model(MODE_ENC, 1'b1, 24'h777777, 8);
        kick(MODE_ENC, 1'b1, 24'h777777, 8);
        @(posedge clk);
        @(negedge clk);
        cif.start = 1'b1;
        cif.mode = MODE_DEC;
        cif.chain_en = 1'b0;
        cif.iv = 24'h0;
        cif.length = 2;
        #1;
        checks++;
        if (cif.err !== 1'b0) begin
            errors++;
            $display("FAIL busystart_err: got %b, expected 0", cif.err);
        end
        @(posedge clk);
        @(negedge clk);
        cif.start = 1'b0;
        wait_done(8, 3, n);
        cmp_frame("busystart", 8);
        checks++;
        if (n !== 10) begin
            errors++;
            $display("FAIL busystart_latency: got %0d cycles, expected 10", n);
        end
    endtask

    initial begin
        cif.start = 1'b0;
        cif.mode = MODE_ENC;
        cif.chain_en = 1'b0;
        cif.iv = '0;
        cif.length = '0;
        cif.ks_valid = 1'b1;
        cif.rd_data = '0;
        repeat (3) @(posedge clk);
        test_reset;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        test_basic;
        test_chain;
        test_gaps;
        test_boundary;
        test_reset_mid;
        test_start_during_run;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_xor_cipher.md
# pixel_xor_cipher

Parametrised multi-channel XOR stream-cipher engine for the image-encryption datapath. It walks a frame buffer through a synchronous read port and consumes one keystream word per pixel from the chaotic-LFSR key generator through a valid/ready handshake. Each result goes out through a write port. Encrypt and decrypt modes are both supported, with optional ciphertext chaining. It sits between the key generator and the frame-buffer RAMs, alongside them in the top level.

## Interface
- NUM_CH, 3, channels per pixel (R,G,B = 3)
- DATA_W, 8, bits per channel
- DEPTH, 16384, maximum pixels per frame
- ADDR_W, $clog2(DEPTH), pixel address width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle frame start request
- mode  in  1  0 = encrypt, 1 = decrypt; sampled at accepted start
- chain_en  in  1  enable ciphertext chaining; sampled at accepted start
- iv  in  NUM_CH*DATA_W  chaining seed; sampled at accepted start
- length  in  ADDR_W+1  pixels to process, 1..DEPTH; sampled at accepted start
- ks_valid  in  1  keystream word available
- ks_data  in  NUM_CH*DATA_W  keystream word, channel 0 in LSBs
- ks_ready  out  1  keystream word consumed this cycle
- rd_en  out  1  frame-buffer read strobe
- rd_addr  out  ADDR_W  read address
- rd_data  in  NUM_CH*DATA_W  read data, valid exactly 1 cycle after rd_en
- wr_en  out  1  result write strobe
- wr_addr  out  ADDR_W  write address
- wr_data  out  NUM_CH*DATA_W  result word
- busy  out  1  frame in progress
- done  out  1  frame complete; level, held until next accepted start or rst
- err  out  1  one-cycle pulse when a start is rejected for bad length

## Operation
- FSM states: IDLE, RUN, FLUSH, DONE. Reset puts the FSM in IDLE and clears every output to 0, plus the issue/write counters and the chain register.
- IDLE/DONE + start:
  - If length is 0 or greater than DEPTH: pulse err and stay in the current state.
  - Otherwise: latch mode, chain_en and length; load the chain register with iv; clear done; go to RUN.
- start while busy is ignored (no err).
- RUN issue rule: ks_ready = (state==RUN) && ks_valid. When ks_ready is high:
  - rd_en = 1 and rd_addr = issue pointer.
  - The ks word is captured into a 1-stage pipeline register.
  - The issue pointer increments.
- When the last address (length-1) is issued, move to FLUSH.
- A cycle with no ks_valid issues nothing: no read, no consume.
- Compute stage, one cycle after issue, with d = rd_data, k = captured ks word, c = chain register:
  - chain_en=0: out = d ^ k.
  - chain_en=1, encrypt: out = d ^ k ^ c; chain register <= out.
  - chain_en=1, decrypt: out = d ^ k ^ c; chain register <= d.
- Each compute cycle asserts wr_en, with wr_addr = the issue address delayed by one cycle and wr_data = out.
- All XORs are bitwise on the full NUM_CH*DATA_W word. There is no carry and no width growth.
- FLUSH: wait for the last write, then go to DONE and set done=1. busy=0 in IDLE and DONE, 1 otherwise.
- Channels are independent lanes; NUM_CH=1 must work.

## Timing
- Latency: 1 cycle from issue (rd_en/ks_ready) to wr_en for the same pixel.
- Throughput: 1 pixel/cycle while ks_valid stays high. A full frame takes length+2 cycles from accepted start to done (start cycle, length issue cycles, last write).
- done rises the cycle after the last wr_en.
- ks_valid gaps: writes gap identically. The chain register holds through gaps.
- length = DEPTH: the final issue address is DEPTH-1. The counter is ADDR_W+1 bits, so there is no wrap before completion.
- rst asserted mid-frame: immediate return to IDLE with all outputs 0. No further wr_en. Already-written pixels are not rolled back.
- start on the same cycle as the final write in FLUSH is ignored.

## Structure
- Shared package `cipher_pkg`: state enum (IDLE/RUN/FLUSH/DONE), MODE_ENC/MODE_DEC constants, default NUM_CH/DATA_W/DEPTH.
- One natural sub-module, `xor_chain_lane`. It holds one channel's compute stage: the XOR plus its slice of the chain register. It is instantiated NUM_CH times by generate.
- RAMs are external; this block holds no frame storage.

## Test plan
- Encrypt, chain off, length=4, data 0x10_20_30.., ks constant 0x0F0F0F: wr_data = data^0x0F0F0F at addr 0..3. done rises 1 cycle after the addr-3 write, 6 cycles after start.
- Encrypt then decrypt, chain on, iv=0xA5A5A5, random 256-pixel frame and keystream: decrypt output equals the original frame; the encrypt output differs from the chain-off result.
- ks_valid low every third cycle over length=16: no rd_en/ks_ready while ks_valid is low, writes are contiguous in address, and the results match the reference model.
- Boundaries: length=1 gives one write to addr 0 and done. length=DEPTH gives a last write to DEPTH-1. length=0 or DEPTH+1 gives an err pulse, busy stays 0, and there are no writes.
- Reset at pixel 5 of 10: all outputs are 0 the same cycle and no writes follow. A new start with length=3 then completes normally from addr 0 with the chain reloaded from iv.
- start pulsed during RUN: ignored, and the frame completes unchanged.
